// File: rtl/axi_read_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : axi_read_arbiter
// Description : Round-robin arbiter that shares one AXI-style read port
//               (AR and R channels) among NREQ requesters. It runs one read
//               at a time and returns the data to the owner with a one-cycle
//               strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
    output logic [ADDR_W-1:0]        ARADDR,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [DATA_W-1:0]        RDATA,
    input  logic                     RVALID,
    output logic                     RREADY,
    output logic [15:0]              txn_count
);

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_last_grant;

    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [NREQ-1:0]    w_sel_onehot;

    // Pick the first requesting index after the previous owner, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_addr = '0;
        v_idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = IDX_W'((int'(r_last_grant) + k) % NREQ);
            if (!w_found && req[v_idx]) begin
                w_found    = 1'b1;
                w_sel      = v_idx;
                w_sel_addr = req_addr[v_idx*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;

    // Transaction sequencer: arbitrate, address handshake, data handshake, respond.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDX_W'(NREQ - 1);
            grant        <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            busy         <= 1'b0;
            ARADDR       <= '0;
            ARVALID      <= 1'b0;
            RREADY       <= 1'b0;
            txn_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        grant        <= w_sel_onehot;
                        ARADDR       <= w_sel_addr;
                        r_last_grant <= w_sel;
                        ARVALID      <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        rsp_data  <= RDATA;
                        rsp_valid <= grant;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= '0;
                    grant     <= '0;
                    busy      <= 1'b0;
                    txn_count <= txn_count + 16'd1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi_read_arbiter
// Description : Self-checking bench for axi_read_arbiter: vector table,
//               randomized reads against a round-robin reference model, and
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    logic                   ACLK = 1'b0;
    logic                   ARESET;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;
    logic [ADDR_W-1:0]      ARADDR;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [DATA_W-1:0]      RDATA;
    logic                   RVALID;
    logic                   RREADY;
    logic [15:0]            txn_count;

    axi_read_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req       (req),
        .req_addr  (req_addr),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .txn_count (txn_count)
    );

    always #5 ACLK = ~ACLK;

    int          checks = 0;
    int          errors = 0;
    int          model_last;
    logic [15:0] model_cnt;

    typedef struct {
        logic [3:0]  mask;
        logic [7:0]  addrs;
        int          arw;
        int          rw;
        logic [31:0] data;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: rotate the search start to just past the last owner.
    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        return 0;
    endfunction

    task automatic reset_dut();
        ARESET  = 1'b1;
        req     = '0;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_araddr", 64'(ARADDR), 64'h0);
        chk("rst_arvalid", 64'(ARVALID), 64'h0);
        chk("rst_rready", 64'(RREADY), 64'h0);
        chk("rst_txn_count", 64'(txn_count), 64'h0);
        ARESET     = 1'b0;
        model_last = NREQ - 1;
        model_cnt  = 16'h0;
    endtask

    // One read, called at the falling edge of an IDLE cycle; the slave waits
    // arw cycles before ARREADY and rw cycles before RVALID.
    task automatic do_read(input logic [3:0] mask, input logic [7:0] addrs, input int arw,
                           input int rw, input logic [31:0] data, input int exp_idx);
        logic [3:0] exp_g;
        logic [1:0] exp_a;
        logic [3:0] noise;
        exp_g = 4'b0001 << exp_idx;
        exp_a = addrs[exp_idx*2 +: 2];
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_grant", 64'(grant), 64'h0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        req      = mask;
        req_addr = addrs;
        ARREADY  = 1'($urandom);
        RVALID   = 1'($urandom);
        RDATA    = $urandom;
        for (int j = 0; j <= arw; j++) begin
            @(negedge ACLK);
            chk("addr_arvalid", 64'(ARVALID), 64'h1);
            chk("addr_araddr", 64'(ARADDR), 64'(exp_a));
            chk("addr_grant", 64'(grant), 64'(exp_g));
            chk("addr_rready", 64'(RREADY), 64'h0);
            chk("addr_busy", 64'(busy), 64'h1);
            ARREADY = (j == arw);
            RVALID  = 1'($urandom);
            noise   = 4'($urandom);
            req     = (noise & ~exp_g) | exp_g;
        end
        for (int j = 0; j <= rw; j++) begin
            @(negedge ACLK);
            chk("data_rready", 64'(RREADY), 64'h1);
            chk("data_arvalid", 64'(ARVALID), 64'h0);
            chk("data_grant", 64'(grant), 64'(exp_g));
            chk("data_rsp_valid", 64'(rsp_valid), 64'h0);
            RVALID  = (j == rw);
            RDATA   = (j == rw) ? data : $urandom;
            ARREADY = 1'($urandom);
        end
        @(negedge ACLK);
        chk("resp_rsp_valid", 64'(rsp_valid), 64'(exp_g));
        chk("resp_rsp_data", 64'(rsp_data), 64'(data));
        chk("resp_grant", 64'(grant), 64'(exp_g));
        chk("resp_busy", 64'(busy), 64'h1);
        chk("resp_rready", 64'(RREADY), 64'h0);
        model_cnt = model_cnt + 16'd1;
        req    = '0;
        RVALID = 1'($urandom);
        @(negedge ACLK);
        chk("post_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("post_busy", 64'(busy), 64'h0);
        chk("post_rsp_data_held", 64'(rsp_data), 64'(data));
        chk("post_txn_count", 64'(txn_count), 64'(model_cnt));
        model_last = exp_idx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  m;
        logic [7:0]  a;
        logic [31:0] d;
        int          idx;

        tbl[0] = '{4'b0001, 8'h02, 0, 0, 32'hDEADBEEF, 4'b0001};
        tbl[1] = '{4'b0010, 8'h0C, 0, 0, 32'h11111111, 4'b0010};
        tbl[2] = '{4'b0011, 8'h0D, 1, 0, 32'h22222222, 4'b0001};
        tbl[3] = '{4'b0010, 8'h04, 0, 2, 32'h33333333, 4'b0010};
        tbl[4] = '{4'b1010, 8'hC4, 3, 5, 32'h44444444, 4'b1000};
        tbl[5] = '{4'b1100, 8'h60, 0, 0, 32'h55555555, 4'b0100};
        tbl[6] = '{4'b1111, 8'h8E, 2, 1, 32'h66666666, 4'b1000};
        tbl[7] = '{4'b0110, 8'h38, 0, 0, 32'h77777777, 4'b0010};
        tbl[8] = '{4'b0101, 8'h21, 1, 1, 32'h88888888, 4'b0100};
        tbl[9] = '{4'b0001, 8'h03, 0, 0, 32'h99999999, 4'b0001};

        req      = '0;
        req_addr = '0;
        RDATA    = '0;
        reset_dut();

        // Vector table: single read, priority skip, backpressure, mixed masks.
        for (int i = 0; i < 10; i++) begin
            idx = 0;
            for (int b = 0; b < NREQ; b++) if (tbl[i].exp_grant[b]) idx = b;
            do_read(tbl[i].mask, tbl[i].addrs, tbl[i].arw, tbl[i].rw, tbl[i].data, idx);
        end

        // Randomized reads against the reference arbitration model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = '0;
                @(negedge ACLK);
                chk("idle_hold_busy", 64'(busy), 64'h0);
            end
            m   = 4'($urandom_range(1, 15));
            a   = 8'($urandom);
            d   = $urandom;
            idx = rr_pick(m, model_last);
            do_read(m, a, $urandom_range(0, 3), $urandom_range(0, 3), d, idx);
        end

        // Round robin with all requesters held and an always-ready slave.
        reset_dut();
        req      = 4'b1111;
        req_addr = 8'hE4;
        ARREADY  = 1'b1;
        RVALID   = 1'b1;
        RDATA    = 32'hA5A50000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge ACLK);
            if (c % 4 == 3) begin
                chk("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ((c / 4) % 4)));
                chk("rr_rsp_data", 64'(rsp_data), 64'(32'hA5A50000 + 32'(c - 1)));
            end else begin
                chk("rr_rsp_quiet", 64'(rsp_valid), 64'h0);
            end
            RDATA = 32'hA5A50000 + 32'(c);
        end
        chk("rr_txn_count", 64'(txn_count), 64'd5);

        // Reset while waiting for data aborts the read without a response.
        reset_dut();
        req      = 4'b0100;
        req_addr = 8'hE4;
        ARREADY  = 1'b1;
        RVALID   = 1'b0;
        @(negedge ACLK);
        chk("abort_addr_grant", 64'(grant), 64'b0100);
        chk("abort_araddr", 64'(ARADDR), 64'b10);
        @(negedge ACLK);
        chk("abort_data_rready", 64'(RREADY), 64'h1);
        ARESET = 1'b1;
        RVALID = 1'b1;
        RDATA  = 32'hBAD0BAD0;
        @(negedge ACLK);
        chk("abort_rready", 64'(RREADY), 64'h0);
        chk("abort_grant", 64'(grant), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("abort_arvalid", 64'(ARVALID), 64'h0);
        ARESET     = 1'b0;
        model_last = NREQ - 1;
        model_cnt  = 16'h0;
        do_read(4'b0100, 8'hE4, 0, 0, 32'hCAFEF00D, 2);
        do_read(4'b1100, 8'hE4, 0, 0, 32'h0BADCAFE, rr_pick(4'b1100, model_last));

        // Counter wrap from a preloaded value near the top.
        reset_dut();
        dut.txn_count = 16'hFFFE;
        model_cnt     = 16'hFFFE;
        do_read(4'b0001, 8'h01, 0, 0, 32'h12345678, 0);
        do_read(4'b0001, 8'h01, 1, 1, 32'h9ABCDEF0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Round-robin arbiter and sequencer that shares one AXI-style read port (AR and R channels) among NREQ internal requesters. It sits between the requesting logic and the 2-bit-address / 32-bit-data read slave. The block accepts one read at a time, drives the address handshake and then the data handshake, and returns RDATA to the granted requester with a one-cycle response strobe.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- ADDR_W, 2: address width.
- DATA_W, 32: data width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester read request (level).
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- grant  out  NREQ  one-hot, current owner; held from arbitration through response.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse to the owner when data returns.
- rsp_data  out  DATA_W  returned data; valid while rsp_valid is nonzero, held afterwards.
- busy  out  1  high in any state other than IDLE.
- ARADDR  out  ADDR_W  read address to slave.
- ARVALID  out  1  address valid.
- ARREADY  in  1  slave address ready.
- RDATA  in  DATA_W  read data from slave.
- RVALID  in  1  slave data valid.
- RREADY  out  1  data ready.
- txn_count  out  16  completed reads; wraps 0xFFFF -> 0x0000.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any req bit is high, select the first requester with req high, searching upward from (last_grant+1) mod NREQ with wrap. Register the one-hot grant, latch its req_addr into ARADDR, update last_grant, and go to ADDR. If no req is high, stay in IDLE.
- ADDR: ARVALID=1 and ARADDR stable. When ARVALID&ARREADY is sampled, go to DATA. ARVALID never drops before the handshake.
- DATA: RREADY=1. When RVALID&RREADY is sampled, latch RDATA into rsp_data and go to RESP. RVALID seen in ADDR is ignored, because RREADY=0 there.
- RESP: rsp_valid = grant for exactly this cycle. Increment txn_count, then go to IDLE. grant clears on entry to IDLE.
- Requesters must keep req and req_addr stable until their rsp_valid, then drop req no later than the cycle after. req changes of non-owners during a transaction are ignored. A req deasserted before it is granted is simply not served.
- Fairness: the owner has lowest priority at the next arbitration. With all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0.
- Reset values: state IDLE, grant=0, rsp_valid=0, rsp_data=0, ARADDR=0, ARVALID=0, RREADY=0, busy=0, txn_count=0, last_grant=NREQ-1, so requester 0 has first priority.
- Reset mid-transaction aborts immediately: all outputs take reset values on the next edge and no rsp_valid is issued.

## Timing
- Best case, with ARREADY and RVALID already high: req high in IDLE at cycle T; ARVALID at T+1; RREADY at T+2; rsp_valid at T+3; IDLE at T+4, where the next arbitration occurs. That gives 4 cycles per read and a 3-cycle request-to-response latency.
- Each ARREADY wait cycle adds 1 cycle in ADDR. Each RVALID wait cycle adds 1 cycle in DATA.
- ARVALID and RREADY are registered state decodes. They are never high in the same cycle.
- grant is stable from T+1 through RESP inclusive.
- busy is high from T+1 through RESP.

## Test plan
- Single read: after reset, req=0001 with addr0=2'b10; slave ARREADY=1, returns RDATA=32'hDEADBEEF one cycle after the handshake. Required: ARADDR=2'b10 with ARVALID at T+1, rsp_valid=0001 and rsp_data=DEADBEEF at T+3 (one cycle wide), txn_count=1.
- Round robin: req=1111 held continuously, immediate slave. Required: rsp_valid sequence 0001,0010,0100,1000,0001, each 4 cycles apart; txn_count=5.
- Backpressure: ARREADY held low 3 cycles, then RVALID delayed 5 cycles. Required: ARVALID high for 4 cycles with ARADDR constant; RREADY high for 6 cycles; rsp_valid 10 cycles after T+1.
- Priority skip: last_grant=1 with req=0011. Required: grant=0001. Then, with req=0010 only, grant=0010.
- Reset mid-operation: assert ARESET while in DATA with grant=0100. Required: next edge gives RREADY=0, grant=0, busy=0, no rsp_valid; the following req=0100 re-arbitrates normally from requester 0 priority.
- Counter wrap: preload via 65536 reads or force. Required: txn_count goes 0xFFFF -> 0x0000 on the next RESP.
